adder_tree_accum: RTL and testbench

Parametrised adder tree with multi-round partial-sum accumulation that reduces per-lane products from the multiplier array into one signed partial sum per output lane. It generalises the fixed 3x3/5x5/7x7 adder to configurable lane count, taps per beat, product width and beats per kernel (`cfg_rounds`). It adds per-tap masking, saturating output, per-lane overflow flags and valid/ready backpressure. It sits between the multiplier array and the partial-sum buffer.

---
 rtl/adder_tree_accum.sv | 185 ++++++++++++++++++
 tb/tb_adder_tree_accum.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_accum.sv
// Masked per-lane adder tree followed by a multi-beat accumulator with signed
// saturation. It sits between the multiplier array and the partial-sum buffer.
module adder_tree_accum #(
    parameter int LANES      = 8,
    parameter int TAPS       = 9,
    parameter int PROD_W     = 16,
    parameter int ACC_W      = 20,
    parameter int MAX_ROUNDS = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [$clog2(MAX_ROUNDS+1)-1:0] cfg_rounds,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*TAPS*PROD_W-1:0]    prod_data,
    input  logic [TAPS-1:0]                 tap_mask,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*ACC_W-1:0]          psum,
    output logic [LANES-1:0]                psum_sat,
    output logic                            busy
);
    localparam int CFG_W  = $clog2(MAX_ROUNDS + 1);
    localparam int SUM_W  = PROD_W + $clog2(TAPS);
    localparam int ACCI_W = SUM_W + $clog2(MAX_ROUNDS);
    localparam int EXT_W  = ACCI_W - ACC_W + 1;

    logic [CFG_W-1:0]              rnd_d, rnd_q;
    logic [CFG_W-1:0]              rounds_lat_d, rounds_lat_q;
    logic [CFG_W-1:0]              eff_rounds_s;
    logic                          t_valid_d, t_valid_q;
    logic                          t_first_d, t_first_q;
    logic                          t_last_d, t_last_q;
    logic [LANES-1:0][SUM_W-1:0]   tree_sum_s;
    logic [LANES-1:0][SUM_W-1:0]   t_sum_d, t_sum_q;
    logic [LANES-1:0][ACCI_W-1:0]  acc_d, acc_q;
    logic [LANES*ACC_W-1:0]        psum_d, psum_q;
    logic [LANES-1:0]              psum_sat_d, psum_sat_q;
    logic                          out_valid_d, out_valid_q;
    logic                          stall_s, accept_s, first_s, last_s;
    logic [SUM_W-1:0]              lane_sum_s;
    logic [ACC_W:0]                sat_s;

    // Returns {clipped, value} with value clamped to the signed ACC_W range.
    function automatic logic [ACC_W:0] saturate(input logic [ACCI_W-1:0] v);
        logic [ACC_W:0] r;
        if (v[ACCI_W-1:ACC_W-1] == {EXT_W{v[ACCI_W-1]}}) begin
            r = {1'b0, v[ACC_W-1:0]};
        end else if (v[ACCI_W-1]) begin
            r = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            r = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
        end
        return r;
    endfunction

    // Masked adder tree: sign-extended products summed per lane
    always_comb begin
        lane_sum_s = '0;
        tree_sum_s = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum_s = '0;
            for (int tp = 0; tp < TAPS; tp++) begin
                if (tap_mask[tp]) begin
                    lane_sum_s = lane_sum_s +
                        SUM_W'($signed(prod_data[(l*TAPS+tp)*PROD_W +: PROD_W]));
                end else begin
                    lane_sum_s = lane_sum_s;
                end
            end
            tree_sum_s[l] = lane_sum_s;
        end
    end

    // Handshake, round counter and tree stage register inputs
    always_comb begin
        stall_s  = out_valid_q && !out_ready;
        accept_s = in_valid && !stall_s;
        if (cfg_rounds == '0) begin
            eff_rounds_s = CFG_W'(1);
        end else if (cfg_rounds > CFG_W'(MAX_ROUNDS)) begin
            eff_rounds_s = CFG_W'(MAX_ROUNDS);
        end else begin
            eff_rounds_s = cfg_rounds;
        end
        first_s = (rnd_q == '0);
        // The latched count is only valid from the second beat on
        if (first_s) begin
            last_s = (eff_rounds_s == CFG_W'(1));
        end else begin
            last_s = (rnd_q == rounds_lat_q - CFG_W'(1));
        end
        rnd_d        = rnd_q;
        rounds_lat_d = rounds_lat_q;
        t_valid_d    = t_valid_q;
        t_first_d    = t_first_q;
        t_last_d     = t_last_q;
        t_sum_d      = t_sum_q;
        if (accept_s) begin
            rnd_d = last_s ? '0 : rnd_q + CFG_W'(1);
            if (first_s) begin
                rounds_lat_d = eff_rounds_s;
            end else begin
                rounds_lat_d = rounds_lat_q;
            end
        end else begin
            rnd_d = rnd_q;
        end
        if (!stall_s) begin
            t_valid_d = accept_s;
            if (accept_s) begin
                t_sum_d   = tree_sum_s;
                t_first_d = first_s;
                t_last_d  = last_s;
            end else begin
                t_sum_d = t_sum_q;
            end
        end else begin
            t_valid_d = t_valid_q;
        end
    end

    // Accumulate stage and saturating output register
    always_comb begin
        acc_d       = acc_q;
        psum_d      = psum_q;
        psum_sat_d  = psum_sat_q;
        out_valid_d = out_valid_q;
        sat_s       = '0;
        if (t_valid_q && !stall_s) begin
            for (int l = 0; l < LANES; l++) begin
                acc_d[l] = t_first_q ? ACCI_W'($signed(t_sum_q[l]))
                                     : acc_q[l] + ACCI_W'($signed(t_sum_q[l]));
            end
        end else begin
            acc_d = acc_q;
        end
        if (t_valid_q && t_last_q && !stall_s) begin
            for (int l = 0; l < LANES; l++) begin
                sat_s                      = saturate(acc_d[l]);
                psum_d[l*ACC_W +: ACC_W]   = sat_s[ACC_W-1:0];
                psum_sat_d[l]              = sat_s[ACC_W];
            end
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_q        <= '0;
            rounds_lat_q <= '0;
            t_valid_q    <= 1'b0;
            t_first_q    <= 1'b0;
            t_last_q     <= 1'b0;
            t_sum_q      <= '0;
            acc_q        <= '0;
            psum_q       <= '0;
            psum_sat_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            rnd_q        <= rnd_d;
            rounds_lat_q <= rounds_lat_d;
            t_valid_q    <= t_valid_d;
            t_first_q    <= t_first_d;
            t_last_q     <= t_last_d;
            t_sum_q      <= t_sum_d;
            acc_q        <= acc_d;
            psum_q       <= psum_d;
            psum_sat_q   <= psum_sat_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready  = !stall_s;
    assign out_valid = out_valid_q;
    assign psum      = psum_q;
    assign psum_sat  = psum_sat_q;
    assign busy      = (rnd_q != '0) || t_valid_q || out_valid_q;

endmodule

// File: tb/tb_adder_tree_accum.sv
// Bench for adder_tree_accum: vector table of uniform groups plus hand-written
// sequences, with a scoreboard queue compared on each output handshake.
module tb_adder_tree_accum;
    localparam int LANES      = 8;
    localparam int TAPS       = 9;
    localparam int PROD_W     = 16;
    localparam int ACC_W      = 20;
    localparam int MAX_ROUNDS = 8;
    localparam int CFG_W      = $clog2(MAX_ROUNDS + 1);

    typedef struct packed {
        logic [LANES*ACC_W-1:0] psum;
        logic [LANES-1:0]       sat;
    } res_t;

    // One group of identical beats; lane l expects eb + es*l
    typedef struct {
        int               cfg;
        int               nbeats;
        int               b;
        int               s;
        logic [TAPS-1:0]  m;
        int               eb;
        int               es;
        logic [LANES-1:0] esat;
    } vec_t;

    logic                          clk;
    logic                          rst;
    logic [CFG_W-1:0]              cfg_rounds;
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*TAPS*PROD_W-1:0]  prod_data;
    logic [TAPS-1:0]               tap_mask;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*ACC_W-1:0]        psum;
    logic [LANES-1:0]              psum_sat;
    logic                          busy;

    res_t exp_q[$];
    vec_t tbl[10];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_outs   = 0;

    adder_tree_accum #(
        .LANES(LANES), .TAPS(TAPS), .PROD_W(PROD_W), .ACC_W(ACC_W), .MAX_ROUNDS(MAX_ROUNDS)
    ) dut (
        .clk(clk), .rst(rst), .cfg_rounds(cfg_rounds), .in_valid(in_valid),
        .in_ready(in_ready), .prod_data(prod_data), .tap_mask(tap_mask),
        .out_valid(out_valid), .out_ready(out_ready), .psum(psum),
        .psum_sat(psum_sat), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic push_lin(input longint base, input longint step, input logic [LANES-1:0] sat);
        res_t r;
        for (int l = 0; l < LANES; l++) r.psum[l*ACC_W +: ACC_W] = ACC_W'(base + step * longint'(l));
        r.sat = sat;
        exp_q.push_back(r);
    endtask

    // Drives one beat (all taps of lane l = b + s*l); returns 1 ns after acceptance
    task automatic send_beat(input int b, input int s, input logic [TAPS-1:0] m, input int cfg);
        int waited;
        bit acc;
        for (int l = 0; l < LANES; l++)
            for (int tp = 0; tp < TAPS; tp++)
                prod_data[(l*TAPS+tp)*PROD_W +: PROD_W] = PROD_W'(b + s * l);
        tap_mask   = m;
        cfg_rounds = CFG_W'(cfg);
        in_valid   = 1'b1;
        waited     = 0;
        acc        = 1'b0;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            waited++;
        end
        #1;
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL send_beat_timeout: in_ready low for %0d cycles, required acceptance", waited);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_out_valid"}, 256'(out_valid), 256'(0));
        chk({tag, "_in_ready"},  256'(in_ready),  256'(1));
        chk({tag, "_busy"},      256'(busy),      256'(0));
        chk({tag, "_psum"},      256'(psum),      256'(0));
        chk({tag, "_psum_sat"},  256'(psum_sat),  256'(0));
    endtask

    // Scoreboard: compare every output handshake against the queue head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_outs++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: psum %h with empty scoreboard", psum);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("psum", 256'(psum), 256'(e.psum));
                chk("psum_sat", 256'(psum_sat), 256'(e.sat));
            end
        end
    end

    initial begin
        res_t r;
        int   n0;
        tbl[0] = '{1, 1, 1,      0,   9'h1FF, 9,       0,    8'h00};
        tbl[1] = '{2, 2, -3,     1,   9'h00F, -24,     8,    8'h00};
        tbl[2] = '{4, 4, 100,    -10, 9'h155, 2000,    -200, 8'h00};
        tbl[3] = '{8, 8, 32767,  0,   9'h1FF, 524287,  0,    8'hFF};
        tbl[4] = '{8, 8, -32768, 0,   9'h1FF, -524288, 0,    8'hFF};
        tbl[5] = '{0, 1, 5,      2,   9'h100, 5,       2,    8'h00};
        tbl[6] = '{12, 8, 1,     0,   9'h003, 16,      0,    8'h00};
        tbl[7] = '{1, 1, -7,     0,   9'h000, 0,       0,    8'h00};
        tbl[8] = '{8, 8, 7281,   0,   9'h1FF, 524232,  0,    8'h00};
        tbl[9] = '{8, 8, 7282,   0,   9'h1FF, 524287,  0,    8'hFF};

        rst = 1'b1; in_valid = 1'b0; prod_data = '0; tap_mask = '0;
        cfg_rounds = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        // Single round: latency and one-cycle pulse
        @(posedge clk); #1;
        push_lin(9, 0, 8'h00);
        send_beat(1, 0, 9'h1FF, 1);
        @(negedge clk); chk("latency_early", 256'(out_valid), 256'(0));
        @(negedge clk); chk("latency_two",   256'(out_valid), 256'(1));
        @(negedge clk); chk("pulse_one",     256'(out_valid), 256'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < tbl[i].nbeats; j++) begin
                if (j == tbl[i].nbeats - 1) push_lin(tbl[i].eb, tbl[i].es, tbl[i].esat);
                send_beat(tbl[i].b, tbl[i].s, tbl[i].m, tbl[i].cfg);
            end
        end
        drain();

        // 7x7-style group with a partial last beat
        n0 = n_outs;
        push_lin(19, 19, 8'h00);
        send_beat(1, 1, 9'h1FF, 3);
        send_beat(1, 1, 9'h1FF, 3);
        send_beat(1, 1, 9'h001, 3);
        drain();
        chk("7x7_single_output", 256'(n_outs - n0), 256'(1));

        // cfg_rounds = 0 gives one result per beat
        for (int v = 1; v <= 3; v++) begin
            push_lin(9 * v, 0, 8'h00);
            send_beat(v, 0, 9'h1FF, 0);
        end
        drain();

        // Mid-group cfg change takes effect only on the next group
        push_lin(18, 0, 8'h00);
        send_beat(1, 0, 9'h1FF, 2);
        send_beat(1, 0, 9'h1FF, 5);
        for (int j = 0; j < 5; j++) begin
            if (j == 4) push_lin(45, 0, 8'h00);
            send_beat(1, 0, 9'h1FF, 5);
        end
        drain();

        // Lanes straddling the positive saturation boundary
        for (int l = 0; l < LANES; l++)
            r.psum[l*ACC_W +: ACC_W] = (l < 2) ? ACC_W'(524160 + 72 * l) : ACC_W'(524287);
        r.sat = 8'hFC;
        exp_q.push_back(r);
        for (int j = 0; j < 8; j++) send_beat(7280, 1, 9'h1FF, 8);
        drain();

        // Backpressure: three single-round beats against a stalled consumer
        out_ready = 1'b0;
        push_lin(9, 0, 8'h00);
        send_beat(1, 0, 9'h1FF, 1);
        push_lin(18, 0, 8'h00);
        send_beat(2, 0, 9'h1FF, 1);
        @(negedge clk);
        chk("bp_in_ready_low", 256'(in_ready), 256'(0));
        chk("bp_out_valid",    256'(out_valid), 256'(1));
        push_lin(27, 0, 8'h00);
        fork
            send_beat(3, 0, 9'h1FF, 1);
            begin
                repeat (2) @(negedge clk);
                chk("bp_hold_ready", 256'(in_ready), 256'(0));
                chk("bp_hold_psum",  256'(psum[ACC_W-1:0]), 256'(9));
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a group
        send_beat(5, 0, 9'h1FF, 3);
        send_beat(5, 0, 9'h1FF, 3);
        @(negedge clk);
        chk("midgroup_busy", 256'(busy), 256'(1));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        @(posedge clk); #1;
        push_lin(27, 0, 8'h00);
        for (int j = 0; j < 3; j++) send_beat(1, 0, 9'h1FF, 3);
        drain();

        repeat (3) @(negedge clk);
        chk("idle_busy",      256'(busy),      256'(0));
        chk("idle_out_valid", 256'(out_valid), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
